// File: rtl/bike_sprite_fetch.sv
// ---------------------------------------------------------------------------
// bike_sprite_fetch
//
// Two-stage pixel pipeline in front of the per-direction bike sprite tables.
// Stage 1 checks whether the scanned pixel lies inside the bike's footprint.
// It registers the sprite-local coordinates and the table select.
// Stage 2 samples the RGB that the tables return and applies transparency
// and crash blinking. It then registers the final BikeOn/RGB for the color
// mapper.
//
// Bike position, direction and crash flag are copied into shadow registers
// only on frame_start, so the sprite cannot tear within a frame.
//
// Ports
//   Clk, Reset_n             clock, asynchronous active-low reset
//   frame_start              one-cycle pulse at start of vertical blank
//   pixel_valid              DrawX/DrawY is a visible pixel this cycle
//   DrawX, DrawY             current scan coordinates
//   BikeX, BikeY, BikeDir    bike top-left corner and heading (game logic)
//   Crashed                  bike blinks while high (sampled per frame)
//   SpriteX, SpriteY, SprDir registered table address / table select
//   SpriteR/G/B              RGB returned combinationally by the tables
//   BikeOn, BikeR/G/B        registered bike pixel result
// Latency: SpriteX/Y/SprDir at N+1, BikeOn/RGB at N+2.
// ---------------------------------------------------------------------------
module bike_sprite_fetch #(
  parameter logic [9:0]  SPRITE_W        = 10'd8,
  parameter logic [9:0]  SPRITE_H        = 10'd8,
  parameter logic [23:0] TRANSPARENT_RGB = 24'h000000,
  parameter logic [5:0]  BLINK_FRAMES    = 6'd15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] BikeX,
  input  logic [9:0] BikeY,
  input  logic [1:0] BikeDir,
  input  logic       Crashed,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY,
  output logic [1:0] SprDir,
  input  logic [7:0] SpriteR,
  input  logic [7:0] SpriteG,
  input  logic [7:0] SpriteB,
  output logic       BikeOn,
  output logic [7:0] BikeR,
  output logic [7:0] BikeG,
  output logic [7:0] BikeB
);

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } blink_state_t;

  // -------------------------------------------------------------------------
  // Per-frame shadow copies of the game inputs
  // -------------------------------------------------------------------------
  logic [9:0] cur_x_reg;
  logic [9:0] cur_y_reg;
  logic [1:0] cur_dir_reg;
  logic       cur_crash_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_x_reg     <= 10'd0;
      cur_y_reg     <= 10'd0;
      cur_dir_reg   <= 2'd0;
      cur_crash_reg <= 1'b0;
    end else if (frame_start) begin
      cur_x_reg     <= BikeX;
      cur_y_reg     <= BikeY;
      cur_dir_reg   <= BikeDir;
      cur_crash_reg <= Crashed;
    end
  end

  // -------------------------------------------------------------------------
  // Blink controller
  // The counter counts frame_starts within the current ON or OFF half-period.
  // The check happens before the increment, so each half-period lasts
  // exactly BLINK_FRAMES frames, and the frame that enters BLINK_ON is the
  // first frame of that half-period.
  // -------------------------------------------------------------------------
  blink_state_t blink_state_reg;
  blink_state_t blink_state_next;
  logic [5:0]   blink_cnt_reg;
  logic [5:0]   blink_cnt_next;
  logic         blank_phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_state_reg <= SOLID;
      blink_cnt_reg   <= 6'd0;
    end else begin
      blink_state_reg <= blink_state_next;
      blink_cnt_reg   <= blink_cnt_next;
    end
  end

  always_comb begin
    blink_state_next = blink_state_reg;
    blink_cnt_next   = blink_cnt_reg;
    if (frame_start) begin
      if (!Crashed) begin
        // Clearing the crash always wins over a pending toggle.
        blink_state_next = SOLID;
        blink_cnt_next   = 6'd0;
      end else begin
        unique case (blink_state_reg)
          SOLID: begin
            blink_state_next = BLINK_ON;
            blink_cnt_next   = 6'd0;
          end
          BLINK_ON, BLINK_OFF: begin
            // '>=' guards against a counter left above the limit.
            if (blink_cnt_reg >= (BLINK_FRAMES - 6'd1)) begin
              blink_cnt_next   = 6'd0;
              blink_state_next = (blink_state_reg == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
              blink_cnt_next = blink_cnt_reg + 6'd1;
            end
          end
          default: begin
            blink_state_next = SOLID;
            blink_cnt_next   = 6'd0;
          end
        endcase
      end
    end
  end

  // BLINK_OFF is only reachable while the latched crash flag is set.
  // The extra term keeps the bike solid if the two ever disagree.
  assign blank_phase = (blink_state_reg == BLINK_OFF) && cur_crash_reg;

  // -------------------------------------------------------------------------
  // Stage 1: footprint test and sprite-local coordinates
  // The bounds are compared in 11 bits. A bike near the right or bottom
  // edge therefore clips cleanly and cannot wrap around to column or row 0.
  // -------------------------------------------------------------------------
  logic [10:0] draw_x_ext;
  logic [10:0] draw_y_ext;
  logic [10:0] left_ext;
  logic [10:0] top_ext;
  logic [10:0] right_ext;
  logic [10:0] bottom_ext;
  logic [9:0]  dist_x;
  logic [9:0]  dist_y;
  logic        hit;

  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};
  assign left_ext   = {1'b0, cur_x_reg};
  assign top_ext    = {1'b0, cur_y_reg};
  assign right_ext  = left_ext + {1'b0, SPRITE_W};
  assign bottom_ext = top_ext + {1'b0, SPRITE_H};

  assign dist_x = DrawX - cur_x_reg;
  assign dist_y = DrawY - cur_y_reg;

  assign hit = pixel_valid
            && (draw_x_ext >= left_ext) && (draw_x_ext < right_ext)
            && (draw_y_ext >= top_ext)  && (draw_y_ext < bottom_ext);

  logic [9:0] sprite_x_reg;
  logic [9:0] sprite_y_reg;
  logic [1:0] spr_dir_reg;
  logic       hit1_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sprite_x_reg <= 10'd0;
      sprite_y_reg <= 10'd0;
      spr_dir_reg  <= 2'd0;
      hit1_reg     <= 1'b0;
    end else begin
      // Outside the footprint the tables are addressed at (0,0). This keeps
      // the table address quiet, and the result is masked by hit1 anyway.
      sprite_x_reg <= hit ? dist_x : 10'd0;
      sprite_y_reg <= hit ? dist_y : 10'd0;
      spr_dir_reg  <= cur_dir_reg;
      hit1_reg     <= hit;
    end
  end

  assign SpriteX = sprite_x_reg;
  assign SpriteY = sprite_y_reg;
  assign SprDir  = spr_dir_reg;

  // -------------------------------------------------------------------------
  // Stage 2: transparency, blink mask and registered color
  // -------------------------------------------------------------------------
  logic [23:0] table_rgb;
  logic        bike_on_next;
  logic        bike_on_reg;

  assign table_rgb    = {SpriteR, SpriteG, SpriteB};
  assign bike_on_next = hit1_reg && (table_rgb != TRANSPARENT_RGB) && !blank_phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bike_on_reg <= 1'b0;
    end else begin
      bike_on_reg <= bike_on_next;
    end
  end

  // One identical register per color channel. Channel 2 is R, 1 is G, 0 is B.
  logic [7:0] chan_reg [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        chan_reg[gi] <= 8'd0;
      end else begin
        chan_reg[gi] <= bike_on_next ? table_rgb[gi*8 +: 8] : 8'd0;
      end
    end
  end

  assign BikeOn = bike_on_reg;
  assign BikeR  = chan_reg[2];
  assign BikeG  = chan_reg[1];
  assign BikeB  = chan_reg[0];

endmodule

// File: tb/tb_bike_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tb_bike_sprite_fetch
//
// Directed bench for bike_sprite_fetch, built with BLINK_FRAMES=2.
// A behavioural model tracks the scene in plain terms: the latched bike
// rectangle, and the number of frames since the crash began. It predicts
// every output on every cycle. Hand-computed per-phase hit counts and first
// hit columns pin the model itself.
// ---------------------------------------------------------------------------
module tb_bike_sprite_fetch;

  localparam int BF = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [9:0] BikeX = '0, BikeY = '0;
  logic [1:0] BikeDir = '0;
  logic       Crashed = 1'b0;
  logic [9:0] SpriteX, SpriteY;
  logic [1:0] SprDir;
  logic [7:0] SpriteR, SpriteG, SpriteB;
  logic       BikeOn;
  logic [7:0] BikeR, BikeG, BikeB;

  bike_sprite_fetch #(
    .SPRITE_W(10'd8), .SPRITE_H(10'd8),
    .TRANSPARENT_RGB(24'h000000), .BLINK_FRAMES(6'd2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .DrawX(DrawX), .DrawY(DrawY),
    .BikeX(BikeX), .BikeY(BikeY), .BikeDir(BikeDir), .Crashed(Crashed),
    .SpriteX(SpriteX), .SpriteY(SpriteY), .SprDir(SprDir),
    .SpriteR(SpriteR), .SpriteG(SpriteG), .SpriteB(SpriteB),
    .BikeOn(BikeOn), .BikeR(BikeR), .BikeG(BikeG), .BikeB(BikeB)
  );

  always #5 Clk = ~Clk;

  // Stub sprite tables.
  // Mode 0: an opaque color that carries the direction and row in B/G.
  // Mode 1: transparent at sprite column 0, pure green elsewhere.
  int mode = 0;

  function automatic logic [23:0] stub(int m, logic [9:0] sx, logic [9:0] sy, logic [1:0] d);
    if (m == 1) return (sx == 10'd0) ? 24'h000000 : 24'h00FF00;
    return {8'hFF, 5'h1F, sy[2:0], 6'h3F, d};
  endfunction

  always_comb {SpriteR, SpriteG, SpriteB} = stub(mode, SpriteX, SpriteY, SprDir);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x = 0, m_y = 0, m_dir = 0, m_crash = 0, m_k = 0;
  logic       e_h1 = 1'b0;
  logic [9:0] e_sx = '0, e_sy = '0;
  logic [1:0] e_dir = '0;
  logic       e_on = 1'b0;
  logic [23:0] e_rgb = '0;
  logic [23:0] t_rgb;
  bit          t_blank, t_hit;
  int          dx_i, dy_i;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_x = 0; m_y = 0; m_dir = 0; m_crash = 0; m_k = 0;
      e_h1 = 0; e_sx = 0; e_sy = 0; e_dir = 0; e_on = 0; e_rgb = 0;
    end else begin
      // Output side: the color the tables return for last cycle's address.
      t_rgb   = stub(mode, e_sx, e_sy, e_dir);
      t_blank = (m_crash != 0) && (((m_k / BF) % 2) == 1);
      e_on    = e_h1 && (t_rgb != 24'h0) && !t_blank;
      e_rgb   = e_on ? t_rgb : 24'h0;
      // Input side: is this pixel inside the latched 8x8 rectangle?
      dx_i  = int'(DrawX);
      dy_i  = int'(DrawY);
      t_hit = pixel_valid && dx_i >= m_x && dx_i < m_x + 8 && dy_i >= m_y && dy_i < m_y + 8;
      e_h1  = t_hit;
      e_sx  = t_hit ? 10'(dx_i - m_x) : 10'd0;
      e_sy  = t_hit ? 10'(dy_i - m_y) : 10'd0;
      e_dir = 2'(m_dir);
      // Frame bookkeeping: m_k counts frames since the crash began.
      if (frame_start) begin
        if (Crashed) m_k = (m_crash != 0) ? m_k + 1 : 0;
        m_crash = Crashed;
        m_x = int'(BikeX); m_y = int'(BikeY); m_dir = int'(BikeDir);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [9:0] dx1 = '0, dx2 = '0;
  always @(posedge Clk) begin
    dx1 <= DrawX;
    dx2 <= dx1;
  end

  int on_cnt = 0;
  int first_col = -1;

  always @(negedge Clk) begin
    check("cycle", {17'd0, SpriteX, SpriteY, SprDir, BikeOn, BikeR, BikeG, BikeB},
                   {17'd0, e_sx, e_sy, e_dir, e_on, e_rgb});
    if (BikeOn) begin
      if (on_cnt == 0) first_col = int'(dx2);
      on_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pix(input int x, input int y, input bit v, input bit fs);
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); pixel_valid = v; frame_start = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(0, 0, 0, 0);
  endtask

  task automatic frame();
    pix(0, 0, 0, 1);
    pix(0, 0, 0, 0);
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) pix(x, y, 1, 0);
  endtask

  task automatic phase_end(string name, input int exp_cnt, input int exp_col);
    idle(3);
    check({name, "_cnt"}, 64'(on_cnt), 64'(exp_cnt));
    if (exp_cnt > 0) check({name, "_col"}, 64'(first_col), 64'(exp_col));
    $display("phase %-12s hits=%0d first_col=%0d", name, on_cnt, first_col);
    on_cnt = 0;
    first_col = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #2 check("reset_outputs", {SpriteX, SpriteY, SprDir, BikeOn, BikeR, BikeG, BikeB}, 64'd0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    idle(2);

    // Basic hit
    BikeX = 10'd100; BikeY = 10'd50; BikeDir = 2'd1; Crashed = 1'b0;
    frame();
    scan(53, 95, 110);
    phase_end("basic", 8, 100);

    // Transparency
    mode = 1;
    scan(53, 95, 110);
    phase_end("transp", 7, 101);
    mode = 0;

    // Edge clip at the right border
    BikeX = 10'd1020; BikeDir = 2'd3;
    frame();
    scan(53, 1016, 1023);
    scan(53, 0, 3);
    phase_end("edge", 4, 1020);

    // Frame latch
    BikeX = 10'd100;
    frame();
    BikeX = 10'd200;
    scan(53, 95, 110);
    phase_end("latch_old", 8, 100);
    frame();
    scan(53, 195, 210);
    phase_end("latch_new", 8, 200);
    BikeX = 10'd100;
    pix(200, 53, 1, 1);
    scan(53, 201, 210);
    phase_end("latch_coinc", 1, 200);
    scan(53, 95, 110);
    phase_end("latch_after", 8, 100);

    // Blink: the pattern by frame is on, on, off, off, ...
    Crashed = 1'b1;
    for (int f = 0; f < 8; f++) begin
      frame();
      scan(53, 100, 107);
      phase_end($sformatf("blink%0d", f), ((f % 4) < 2) ? 8 : 0, 100);
    end
    Crashed = 1'b0;
    frame();
    scan(53, 100, 107);
    phase_end("solid_again", 8, 100);
    // Crashed rising mid-frame must not blank the current frame.
    Crashed = 1'b1;
    scan(53, 100, 107);
    phase_end("mid_crash", 8, 100);
    Crashed = 1'b0;
    frame();

    // Reset mid-line during a hit run
    BikeX = 10'd0; BikeY = 10'd0; BikeDir = 2'd2;
    frame();
    for (int x = 0; x < 4; x++) pix(x, 3, 1, 0);
    #2 Reset_n = 1'b0;
    #1 check("async_clear", {SpriteX, SpriteY, SprDir, BikeOn, BikeR, BikeG, BikeB}, 64'd0);
    pix(4, 3, 1, 0);
    pix(5, 3, 1, 0);
    #2 Reset_n = 1'b1;
    #1 check("post_rel0", 64'(BikeOn), 64'd0);
    pix(6, 3, 1, 0);
    @(negedge Clk); #1 check("post_rel1", 64'(BikeOn), 64'd0);
    pix(7, 3, 1, 0);
    @(negedge Clk); #1 check("post_rel2", 64'(BikeOn), 64'd1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
